// File: rtl/apb4_master_ctrl.sv
`default_nettype none
// ============================================================================
// apb4_master_ctrl : pops one command, runs one APB4 transfer with a PREADY
//                    timeout, then pushes one packed response word.
// Revision        : 1.0
// ============================================================================
module apb4_master_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256,
  parameter int CMD_W   = 1 + 3 + DATA_W/8 + ADDR_W + DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                cmd_empty,
  output logic                cmd_r_en,
  input  logic [CMD_W-1:0]    cmd_data,
  input  logic                rsp_full,
  output logic                rsp_w_en,
  output logic [DATA_W+2:0]   rsp_data,
  output logic [ADDR_W-1:0]   paddr,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  output logic [2:0]          pprot,
  input  logic                pready,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pslverr,
  output logic                busy,
  output logic [7:0]          err_cnt
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic [STRB_W-1:0]   pstrb_q;
  logic [2:0]          pprot_q;
  logic [DATA_W+2:0]   rsp_q;
  logic [7:0]          err_q;
  logic [7:0]          err_d;
  logic                timeout_hit;

  logic                cmd_write;
  logic [2:0]          cmd_prot;
  logic [STRB_W-1:0]   cmd_strb;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;

  assign {cmd_write, cmd_prot, cmd_strb, cmd_addr, cmd_wdata} = cmd_data;

  // FIFO handshakes are gated by reset so nothing is popped or pushed while held.
  assign cmd_r_en = reset && (state_q == IDLE) && en && !cmd_empty;
  assign rsp_w_en = reset && (state_q == RESP) && !rsp_full;

  // cnt_q holds the number of ACCESS cycles already completed.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign err_d       = (rsp_q[DATA_W] && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      rsp_q     <= '0;
      err_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_r_en) state_q <= FETCH;
        end
        FETCH: begin
          paddr_q  <= cmd_addr;
          pwdata_q <= cmd_wdata;
          pwrite_q <= cmd_write;
          pprot_q  <= cmd_prot;
          pstrb_q  <= cmd_write ? cmd_strb : '0;
          psel_q   <= 1'b1;
          state_q  <= SETUP;
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          if (pready) begin
            rsp_q     <= {pwrite_q, 1'b0, pslverr, (pwrite_q ? {DATA_W{1'b0}} : prdata)};
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= RESP;
          end else if (timeout_hit) begin
            rsp_q     <= {pwrite_q, 2'b11, {DATA_W{1'b0}}};
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (rsp_w_en) begin
            err_q   <= err_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign psel     = psel_q;
  assign penable  = penable_q;
  assign pwrite   = pwrite_q;
  assign paddr    = paddr_q;
  assign pwdata   = pwdata_q;
  assign pstrb    = pstrb_q;
  assign pprot    = pprot_q;
  assign rsp_data = rsp_q;
  assign err_cnt  = err_q;
  assign busy     = (state_q != IDLE);

endmodule
`default_nettype wire
